// File: rtl/otter_mem_pkg.sv
// Shared types and lane helpers for the OTTER data-memory responder.
package otter_mem_pkg;

  localparam logic [31:0] DEFAULT_IO_BASE = 32'h1100_0000;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_t;

  // The reserved encoding 2'b11 behaves as a word access.
  function automatic mem_size_t decode_size(input logic [1:0] raw);
    mem_size_t size;
    case (raw)
      2'b00:   size = BYTE;
      2'b01:   size = HALF;
      default: size = WORD;
    endcase
    return size;
  endfunction

  // Enables wrap around the word, so a half at offset 3 covers bytes 3 and 0.
  function automatic logic [3:0] byte_enables(input mem_size_t size, input logic [1:0] byte_off);
    logic [7:0] be;
    case (size)
      BYTE:    be = 8'h01;
      HALF:    be = 8'h03;
      default: be = 8'h0F;
    endcase
    be = be << byte_off;
    return be[3:0] | be[7:4];
  endfunction

  // Replicate the store data, then rotate so the low byte lands on the first enabled lane.
  function automatic logic [31:0] lane_data(input mem_size_t size, input logic [1:0] byte_off,
                                            input logic [31:0] wd);
    logic [31:0] rep;
    logic [63:0] dbl;
    case (size)
      BYTE:    rep = {4{wd[7:0]}};
      HALF:    rep = {2{wd[15:0]}};
      default: rep = wd;
    endcase
    dbl = {rep, rep} << {byte_off, 3'b000};
    return dbl[63:32];
  endfunction

  function automatic logic misaligned(input mem_size_t size, input logic [1:0] byte_off);
    return ((size == HALF) && byte_off[0]) || ((size == WORD) && (byte_off != 2'b00));
  endfunction

endpackage

// File: rtl/otter_load_ext.sv
// Load lane select and sign/zero extension; offsets wrap modulo the word.
module otter_load_ext
  import otter_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  byte_off,
  input  mem_size_t   size,
  input  logic        zero_ext,
  output logic [31:0] result
);

  logic [63:0] dbl;
  logic [31:0] rot;

  always_comb begin
    dbl = {word, word} >> {byte_off, 3'b000};
    rot = dbl[31:0];
    case (size)
      BYTE:    result = zero_ext ? {24'b0, rot[7:0]} : {{24{rot[7]}}, rot[7:0]};
      HALF:    result = zero_ext ? {16'b0, rot[15:0]} : {{16{rot[15]}}, rot[15:0]};
      default: result = rot;
    endcase
  end

endmodule

// File: rtl/otter_dmem_resp.sv
// OTTER data-port responder: RAM plus memory-mapped IO with programmable wait states.
// Define OTTER_DMEM_ERR_EN to flag and suppress misaligned accesses via RSP_ERR.
module otter_dmem_resp
  import otter_mem_pkg::*;
#(
  parameter int          WAIT_CYCLES = 1,
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] IO_BASE     = DEFAULT_IO_BASE
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WE,
  input  logic [31:0] REQ_ADDR,
  input  logic [31:0] REQ_WDATA,
  input  logic [1:0]  REQ_SIZE,
  input  logic        REQ_SIGN,
  input  logic [31:0] IO_IN,
  output logic        RSP_VALID,
  output logic        RSP_ERR,
  output logic [31:0] RSP_RDATA,
  output logic        IO_WR,
  output logic [31:0] IO_ADDR,
  output logic [31:0] IO_OUT
);

  localparam int         IDX_W     = $clog2(DEPTH_WORDS);
  localparam bit         NO_WAIT   = (WAIT_CYCLES == 0);
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  dmem_state_t state;
  logic [3:0]  cnt;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  mem_size_t   size_q;
  logic        sign_q;

  logic        rsp_valid_q;
  logic        io_wr_q;
  logic [31:0] rdata_q;
  logic [31:0] io_addr_q;
  logic [31:0] io_out_q;

  logic [31:0] mem [DEPTH_WORDS];

  // In IDLE the live request is the operation; otherwise the latched copy is.
  logic             idle;
  logic             accept;
  logic             op_we;
  logic [31:0]      op_addr;
  logic [31:0]      op_wdata;
  mem_size_t        op_size;
  logic             op_sign;
  logic             op_io;
  logic             op_err;
  logic             enter_resp;
  logic             ram_we;
  logic [IDX_W-1:0] word_idx;
  logic [3:0]       op_be;
  logic [31:0]      op_lanes;
  logic [31:0]      ld_src;
  logic [31:0]      ld_result;

  assign idle     = (state == IDLE);
  assign accept   = idle && REQ_VALID;
  assign op_we    = idle ? REQ_WE    : we_q;
  assign op_addr  = idle ? REQ_ADDR  : addr_q;
  assign op_wdata = idle ? REQ_WDATA : wdata_q;
  assign op_size  = idle ? decode_size(REQ_SIZE) : size_q;
  assign op_sign  = idle ? REQ_SIGN  : sign_q;

  assign op_io      = (op_addr >= IO_BASE);
  assign enter_resp = (accept && NO_WAIT) || ((state == WAIT) && (cnt == 4'd0));
  assign word_idx   = op_addr[IDX_W+1:2];
  assign op_be      = byte_enables(op_size, op_addr[1:0]);
  assign op_lanes   = lane_data(op_size, op_addr[1:0], op_wdata);
  assign ld_src     = op_io ? IO_IN : mem[word_idx];

`ifdef OTTER_DMEM_ERR_EN
  logic rsp_err_q;

  assign op_err  = misaligned(op_size, op_addr[1:0]);
  assign RSP_ERR = rsp_err_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) rsp_err_q <= 1'b0;
    else        rsp_err_q <= enter_resp && op_err;
  end
`else
  assign op_err  = 1'b0;
  assign RSP_ERR = 1'b0;
`endif

  // RST_N gate keeps a store that coincides with reset from landing in RAM.
  assign ram_we = enter_resp && op_we && !op_io && !op_err && RST_N;

  otter_load_ext u_load_ext (
    .word     (ld_src),
    .byte_off (op_addr[1:0]),
    .size     (op_size),
    .zero_ext (op_sign),
    .result   (ld_result)
  );

  always_ff @(posedge CLK) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (op_be[b]) mem[word_idx][8*b +: 8] <= op_lanes[8*b +: 8];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      size_q      <= BYTE;
      sign_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      io_wr_q     <= 1'b0;
      rdata_q     <= 32'd0;
      io_addr_q   <= 32'd0;
      io_out_q    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            we_q    <= REQ_WE;
            addr_q  <= REQ_ADDR;
            wdata_q <= REQ_WDATA;
            size_q  <= decode_size(REQ_SIZE);
            sign_q  <= REQ_SIGN;
            if (NO_WAIT) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= WAIT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= RESP;
          else             cnt   <= cnt - 4'd1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase

      rsp_valid_q <= enter_resp;
      io_wr_q     <= enter_resp && op_we && op_io && !op_err;
      if (enter_resp) begin
        if (op_err)      rdata_q <= 32'd0;
        else if (!op_we) rdata_q <= ld_result;
        if (op_we && op_io && !op_err) begin
          io_addr_q <= op_addr;
          io_out_q  <= op_lanes;
        end
      end
    end
  end

  assign REQ_READY = idle;
  assign RSP_VALID = rsp_valid_q;
  assign RSP_RDATA = rdata_q;
  assign IO_WR     = io_wr_q;
  assign IO_ADDR   = io_addr_q;
  assign IO_OUT    = io_out_q;

endmodule

// File: tb/tb_otter_dmem_resp.sv
// Directed bench for otter_dmem_resp: three instances with 1, 3 and 0 wait states.
module tb_otter_dmem_resp;

  logic        CLK = 1'b0;
  logic        rstN;
  logic        reqValid [3];
  logic        reqWe;
  logic [31:0] reqAddr;
  logic [31:0] reqWdata;
  logic [1:0]  reqSize;
  logic        reqSign;
  logic [31:0] ioIn;

  logic        reqReady [3];
  logic        rspValid [3];
  logic        rspErr   [3];
  logic        ioWr     [3];
  logic [31:0] rspRdata [3];
  logic [31:0] ioAddr   [3];
  logic [31:0] ioOut    [3];

  int testsRun    = 0;
  int testsFailed = 0;

  int          obsLat;
  logic        obsTimeout;
  logic [31:0] obsRdata;
  logic        obsErr;
  logic        obsIoWr;
  logic [31:0] obsIoAddr;
  logic [31:0] obsIoOut;
  logic        obsValidAfter;
  logic        obsIoWrAfter;

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    otter_dmem_resp #(
      .WAIT_CYCLES ((g == 0) ? 1 : ((g == 1) ? 3 : 0)),
      .DEPTH_WORDS (1024),
      .IO_BASE     (32'h1100_0000)
    ) u_dut (
      .CLK       (CLK),
      .RST_N     (rstN),
      .REQ_VALID (reqValid[g]),
      .REQ_READY (reqReady[g]),
      .REQ_WE    (reqWe),
      .REQ_ADDR  (reqAddr),
      .REQ_WDATA (reqWdata),
      .REQ_SIZE  (reqSize),
      .REQ_SIGN  (reqSign),
      .IO_IN     (ioIn),
      .RSP_VALID (rspValid[g]),
      .RSP_ERR   (rspErr[g]),
      .RSP_RDATA (rspRdata[g]),
      .IO_WR     (ioWr[g]),
      .IO_ADDR   (ioAddr[g]),
      .IO_OUT    (ioOut[g])
    );
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  // Issue one request, wait for its response, capture the RESP cycle and the cycle after.
  task automatic applyStimulus(input int inst, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [1:0] size, input logic zext);
    int waited;
    @(negedge CLK);
    reqWe    = we;
    reqAddr  = addr;
    reqWdata = wdata;
    reqSize  = size;
    reqSign  = zext;
    reqValid[inst] = 1'b1;
    waited = 0;
    while (!reqReady[inst] && waited < 20) begin
      @(negedge CLK);
      waited++;
    end
    @(posedge CLK);
    #1 reqValid[inst] = 1'b0;
    obsLat = 0;
    do begin
      @(negedge CLK);
      obsLat++;
    end while (!rspValid[inst] && obsLat < 20);
    obsTimeout = (waited >= 20) || !rspValid[inst];
    obsRdata   = rspRdata[inst];
    obsErr     = rspErr[inst];
    obsIoWr    = ioWr[inst];
    obsIoAddr  = ioAddr[inst];
    obsIoOut   = ioOut[inst];
    @(negedge CLK);
    obsValidAfter = rspValid[inst];
    obsIoWrAfter  = ioWr[inst];
  endtask

  task automatic checkResponse(input string tag, input int expLat);
    checkOutput({tag, "_timeout"}, 32'(obsTimeout), 32'd0);
    checkOutput({tag, "_latency"}, 32'(obsLat), 32'(expLat));
    checkOutput({tag, "_pulse"}, 32'(obsValidAfter), 32'd0);
  endtask

  initial begin
    logic sawValid;
    rstN     = 1'b0;
    reqValid = '{1'b0, 1'b0, 1'b0};
    reqWe    = 1'b0;
    reqAddr  = 32'd0;
    reqWdata = 32'd0;
    reqSize  = 2'b10;
    reqSign  = 1'b0;
    ioIn     = 32'h89AB_CDEF;

    repeat (2) @(negedge CLK);
    checkOutput("rst_ready",  32'(reqReady[0]), 32'd1);
    checkOutput("rst_valid",  32'(rspValid[0]), 32'd0);
    checkOutput("rst_err",    32'(rspErr[0]),   32'd0);
    checkOutput("rst_iowr",   32'(ioWr[0]),     32'd0);
    checkOutput("rst_rdata",  rspRdata[0],      32'd0);
    checkOutput("rst_ioaddr", ioAddr[0],        32'd0);
    checkOutput("rst_ioout",  ioOut[0],         32'd0);
    checkOutput("rst_ready1", 32'(reqReady[1]), 32'd1);
    rstN = 1'b1;

    // Word store and load-back, one wait state.
    applyStimulus(0, 1'b1, 32'h100, 32'hDEAD_BEEF, 2'b10, 1'b0);
    checkResponse("st_word", 2);
    checkOutput("st_word_err", 32'(obsErr), 32'd0);
    applyStimulus(0, 1'b0, 32'h100, 32'd0, 2'b10, 1'b0);
    checkResponse("ld_word", 2);
    checkOutput("ld_word_data", obsRdata, 32'hDEAD_BEEF);

    // Byte store into the top lane, then signed/unsigned/word views.
    applyStimulus(0, 1'b1, 32'h103, 32'h0000_0080, 2'b00, 1'b0);
    checkResponse("st_byte", 2);
    applyStimulus(0, 1'b0, 32'h103, 32'd0, 2'b00, 1'b0);
    checkOutput("ld_byte_s", obsRdata, 32'hFFFF_FF80);
    applyStimulus(0, 1'b0, 32'h103, 32'd0, 2'b00, 1'b1);
    checkOutput("ld_byte_u", obsRdata, 32'h0000_0080);
    applyStimulus(0, 1'b0, 32'h100, 32'd0, 2'b10, 1'b0);
    checkOutput("ld_word2", obsRdata, 32'h80AD_BEEF);
    applyStimulus(0, 1'b0, 32'h102, 32'd0, 2'b01, 1'b0);
    checkOutput("ld_half_s", obsRdata, 32'hFFFF_80AD);
    applyStimulus(0, 1'b0, 32'h100, 32'd0, 2'b01, 1'b1);
    checkOutput("ld_half_u", obsRdata, 32'h0000_BEEF);
    applyStimulus(0, 1'b0, 32'h101, 32'd0, 2'b00, 1'b0);
    checkOutput("ld_byte1_s", obsRdata, 32'hFFFF_FFBE);
    applyStimulus(0, 1'b0, 32'h100, 32'd0, 2'b11, 1'b0);
    checkOutput("ld_size11", obsRdata, 32'h80AD_BEEF);

    // IO store must not touch the RAM word it would alias onto.
    applyStimulus(0, 1'b1, 32'h000, 32'hCAFE_F00D, 2'b10, 1'b0);
    applyStimulus(0, 1'b1, 32'h1100_0000, 32'hABCD_1234, 2'b01, 1'b0);
    checkResponse("io_st", 2);
    checkOutput("io_st_wr",     32'(obsIoWr),      32'd1);
    checkOutput("io_st_wr_end", 32'(obsIoWrAfter), 32'd0);
    checkOutput("io_st_addr",   obsIoAddr,         32'h1100_0000);
    checkOutput("io_st_data",   obsIoOut,          32'h1234_1234);
    applyStimulus(0, 1'b0, 32'h000, 32'd0, 2'b10, 1'b0);
    checkOutput("io_ram_kept", obsRdata, 32'hCAFE_F00D);
    applyStimulus(0, 1'b0, 32'h1100_0001, 32'd0, 2'b00, 1'b0);
    checkOutput("io_ld_data", obsRdata, 32'hFFFF_FFCD);
    checkOutput("io_ld_nowr", 32'(obsIoWr), 32'd0);

    // Bits above the word index are ignored below IO_BASE.
    applyStimulus(0, 1'b1, 32'h1000, 32'h0102_0304, 2'b10, 1'b0);
    applyStimulus(0, 1'b0, 32'h000, 32'd0, 2'b10, 1'b0);
    checkOutput("alias", obsRdata, 32'h0102_0304);

`ifdef OTTER_DMEM_ERR_EN
    applyStimulus(0, 1'b1, 32'h102, 32'h1111_1111, 2'b10, 1'b0);
    checkResponse("mis_st", 2);
    checkOutput("mis_st_err",   32'(obsErr), 32'd1);
    checkOutput("mis_st_rdata", obsRdata,    32'd0);
    applyStimulus(0, 1'b0, 32'h100, 32'd0, 2'b10, 1'b0);
    checkOutput("mis_kept",     obsRdata,    32'h80AD_BEEF);
    checkOutput("mis_kept_err", 32'(obsErr), 32'd0);
    applyStimulus(0, 1'b0, 32'h101, 32'd0, 2'b01, 1'b0);
    checkOutput("mis_ld_err",   32'(obsErr), 32'd1);
    checkOutput("mis_ld_rdata", obsRdata,    32'd0);
`else
    applyStimulus(0, 1'b1, 32'h103, 32'h0000_A5B6, 2'b01, 1'b0);
    checkOutput("wrap_st_err", 32'(obsErr), 32'd0);
    applyStimulus(0, 1'b0, 32'h100, 32'd0, 2'b10, 1'b0);
    checkOutput("wrap_word", obsRdata, 32'hB6AD_BEA5);
    applyStimulus(0, 1'b0, 32'h103, 32'd0, 2'b01, 1'b1);
    checkOutput("wrap_half", obsRdata, 32'h0000_A5B6);
`endif

    // Three wait states: reset during WAIT drops the pending byte store.
    applyStimulus(1, 1'b1, 32'h200, 32'h1122_3344, 2'b10, 1'b0);
    checkResponse("w3_st", 4);
    @(negedge CLK);
    reqWe    = 1'b1;
    reqAddr  = 32'h200;
    reqWdata = 32'h0000_0055;
    reqSize  = 2'b00;
    reqValid[1] = 1'b1;
    @(posedge CLK);
    #1 reqValid[1] = 1'b0;
    @(negedge CLK);
    checkOutput("w3_in_wait", 32'(reqReady[1]), 32'd0);
    rstN = 1'b0;
    #1;
    checkOutput("w3_rst_ready", 32'(reqReady[1]), 32'd1);
    checkOutput("w3_rst_valid", 32'(rspValid[1]), 32'd0);
    checkOutput("w3_rst_rdata0", rspRdata[0],     32'd0);
    sawValid = 1'b0;
    repeat (5) begin
      @(negedge CLK);
      sawValid = sawValid | rspValid[1] | ioWr[1];
    end
    rstN = 1'b1;
    repeat (5) begin
      @(negedge CLK);
      sawValid = sawValid | rspValid[1] | ioWr[1];
    end
    checkOutput("w3_no_resp", 32'(sawValid), 32'd0);
    applyStimulus(1, 1'b0, 32'h200, 32'd0, 2'b10, 1'b0);
    checkResponse("w3_ld", 4);
    checkOutput("w3_ld_old", obsRdata, 32'h1122_3344);

    // Zero wait states with REQ_VALID held: accept every other cycle.
    applyStimulus(2, 1'b0, 32'h1100_0000, 32'd0, 2'b10, 1'b0);
    checkResponse("w0_ld", 1);
    checkOutput("w0_ld_io", obsRdata, 32'h89AB_CDEF);
    @(negedge CLK);
    reqWe   = 1'b0;
    reqAddr = 32'h1100_0000;
    reqSize = 2'b10;
    reqValid[2] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("w0_ready_%0d", i), 32'(reqReady[2]), 32'(i % 2 == 0));
      checkOutput($sformatf("w0_valid_%0d", i), 32'(rspValid[2]), 32'(i % 2 == 1));
      @(negedge CLK);
    end
    reqValid[2] = 1'b0;
    @(negedge CLK);
    checkOutput("w0_stop", 32'(rspValid[2]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/otter_dmem_resp.md
OTTER_DMEM_RESP -- requirements
Module: otter_dmem_resp

Interface
REQ-001 The block SHALL have parameter WAIT_CYCLES, default 1, meaning wait states between request accept and response (0..15).
REQ-002 The block SHALL have parameter DEPTH_WORDS, default 4096, meaning the number of 32-bit RAM words, a power of two.
REQ-003 The block SHALL have parameter IO_BASE, default 32'h1100_0000, meaning the lowest address decoded as IO.
REQ-004 The block SHALL have port CLK, input, 1 bit: the single clock, rising edge.
REQ-005 The block SHALL have port RST_N, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port REQ_VALID, input, 1 bit: the CPU data-port request is present.
REQ-007 The block SHALL have port REQ_READY, output, 1 bit: the responder can accept a request.
REQ-008 The block SHALL have port REQ_WE, input, 1 bit: 1 means store, 0 means load.
REQ-009 The block SHALL have ports REQ_ADDR, REQ_WDATA, IO_IN, IO_ADDR, IO_OUT and RSP_RDATA, each 32 bits: byte address, store data, IO read data, IO address out, IO write data out, and load result; REQ_* and IO_IN are inputs, the rest are outputs.
REQ-010 The block SHALL have port REQ_SIZE, input, 2 bits: 00 byte, 01 halfword, 10 word.
REQ-011 The block SHALL have port REQ_SIGN, input, 1 bit: 1 means zero-extend loads (funct3[2]), 0 means sign-extend.
REQ-012 The block SHALL have outputs RSP_VALID, RSP_ERR and IO_WR, 1 bit each: response strobe, error flag and IO write strobe.

Function
REQ-013 The FSM SHALL have states IDLE, WAIT and RESP; REQ_READY=1 only in IDLE.
REQ-014 An accept SHALL be REQ_VALID&&REQ_READY at a rising edge; it latches WE, ADDR, WDATA, SIZE and SIGN, then enters WAIT if WAIT_CYCLES>0, else RESP.
REQ-015 In WAIT, a 4-bit counter SHALL count from WAIT_CYCLES-1 down to 0 and then enter RESP.
REQ-016 In RESP, RSP_VALID SHALL be 1 for exactly one cycle, followed by an unconditional return to IDLE; accept-to-RSP_VALID latency is WAIT_CYCLES+1 cycles.
REQ-017 The RAM store SHALL commit on the edge entering RESP, using byte enables from SIZE and ADDR[1:0]: byte 0001<<a, half 0011<<a, word 1111.
REQ-018 Store data SHALL be lane-replicated: byte {4{wd[7:0]}}, half {2{wd[15:0]}}.
REQ-019 The load result SHALL be registered at entry to RESP and held until the next RESP; the lane is selected by ADDR[1:0], then sign- or zero-extended per SIGN and SIZE.
REQ-020 An address >= IO_BASE SHALL be IO: no RAM access; a store pulses IO_WR for the RESP cycle with IO_ADDR and IO_OUT set to the latched address and data; a load samples IO_IN at entry to RESP.
REQ-021 A RAM word index SHALL be ADDR[$clog2(DEPTH_WORDS)+1:2]; upper bits below IO_BASE are ignored (aliasing).
REQ-022 REQ_VALID in WAIT or RESP SHALL be ignored, and it is not captured later without being held.
REQ-023 SIZE=11 SHALL be treated as word.

Reset
REQ-024 RST_N=0 SHALL force IDLE, counter 0, and REQ_READY=1, RSP_VALID=0, RSP_ERR=0, IO_WR=0, RSP_RDATA=0, IO_ADDR=0, IO_OUT=0 immediately.
REQ-025 Reset mid-operation SHALL discard a pending store (no RAM write, no IO_WR); RAM contents are not initialized by reset.

Configuration
REQ-026 With OTTER_DMEM_ERR_EN defined, misalignment (half with a[0]=1, word with a[1:0]!=0) SHALL assert RSP_ERR with RSP_VALID, suppress the RAM write or IO_WR, and return RSP_RDATA=0.
REQ-027 Without OTTER_DMEM_ERR_EN, RSP_ERR SHALL be tied 0 and misaligned accesses SHALL use lanes modulo word (half at a=3 uses bytes 3 and 0 of the same word).

Structure
REQ-028 The package otter_mem_pkg SHALL hold the mem_size_t enum (BYTE, HALF, WORD), the dmem_state_t enum (IDLE, WAIT, RESP) and the default IO_BASE constant.
REQ-029 One sub-module, otter_load_ext (combinational lane select plus extend), SHALL be instantiated once.

Verification
REQ-030 Test: with WAIT_CYCLES=1, store word 0xDEADBEEF at 0x100, then load word at 0x100 -> RSP_VALID 2 cycles after each accept, with RSP_RDATA=0xDEADBEEF.
REQ-031 Test: store byte 0x80 at 0x103, then load byte signed at 0x103 -> 0xFFFFFF80; unsigned -> 0x00000080; word at 0x100 -> 0x80ADBEEF.
REQ-032 Test: store half 0x1234 to 0x1100_0000 -> IO_WR is 1 for one cycle with IO_ADDR=0x1100_0000 and IO_OUT=0x12341234, and RAM is unchanged.
REQ-033 Test: with OTTER_DMEM_ERR_EN, store word to 0x102 -> RSP_ERR=1 with RSP_VALID, and a following load of 0x100 still returns the prior value.
REQ-034 Test: with WAIT_CYCLES=3, assert RST_N=0 in WAIT during a store of 0x55 to 0x200 -> no RSP_VALID, REQ_READY=1, and a later load of 0x200 returns the old contents.
REQ-035 Test: with WAIT_CYCLES=0, hold REQ_VALID continuously -> accepts occur every 2 cycles, REQ_READY toggles 1,0, and each RSP_VALID is a single-cycle pulse.
